fifo_drain_packer: RTL
======================

Name: fifo_drain_packer

Overview:
- Reader-side companion to the team's synchronous `fifo`.
- Drains DW-bit entries through the fifo's `r_en`/`empty`/`data_out` interface and packs PACK consecutive entries into one wide word.
- Presents each packed word on a valid/ready stream.
- A `flush` request emits a partial word, so the downstream block never waits on a trickle of data.

Parameters:
- DW, 8, width of one fifo entry.
- PACK, 4, entries per output word (2..16).
- CW, 16, width of the `words_sent` counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-low (0 = reset asserted).
- fifo_empty  input  1  fifo `empty` flag.
- fifo_rd_data  input  DW  fifo `data_out`; registered in the fifo, valid the cycle after a read.
- fifo_r_en  output  1  fifo read enable.
- flush  input  1  single-cycle request to emit the partial word.
- m_valid  output  1  output word valid.
- m_ready  input  1  downstream accept.
- m_data  output  DW*PACK  packed word; entry 0 in bits [DW-1:0].
- m_count  output  clog2(PACK+1)  number of valid entries in m_data.
- flush_done  output  1  one-cycle pulse when a flush completes.
- words_sent  output  CW  count of accepted output words.

Behaviour:
- Reset (rst=0, async):
  - m_valid=0, m_data=0, m_count=0, flush_done=0, words_sent=0.
  - Internal state: lane count cnt=0, pend=0, flush_req=0, state=FILL.
  - fifo_r_en=0 while rst=0.
- States are FILL and HOLD.
- fifo_r_en (combinational) = (state==FILL) && !fifo_empty && !flush_req && (cnt+pend < PACK).
  - Back-to-back reads are allowed.
  - At most PACK reads are outstanding or captured per word.
- pend (registered) = fifo_r_en of the previous cycle. When pend=1:
  - fifo_rd_data is written into lane cnt.
  - cnt increments by 1.
- FILL -> HOLD occurs in the cycle where a capture makes cnt==PACK:
  - m_data = packed lanes, m_count=PACK, m_valid=1.
  - Latency: first read to m_valid = PACK+1 cycles with the fifo never empty.
- HOLD:
  - No fifo reads.
  - m_data and m_count are held stable while m_valid && !m_ready.
  - On m_valid && m_ready: m_valid=0, cnt=0, lanes cleared to 0, words_sent+1 (wraps 2^CW-1 -> 0), next state FILL.
- Flush:
  - flush=1 in any state sets flush_req. A flush arriving while flush_req=1 is absorbed.
  - In FILL with flush_req=1 and pend=0:
    - If cnt>0: m_data = captured lanes with unused upper lanes zero, m_count=cnt, m_valid=1, go to HOLD.
    - If cnt==0: flush_done=1 for one cycle, flush_req=0.
  - When a word emitted from HOLD is accepted while flush_req=1, the flush completes via the cnt==0 path on the next FILL cycle, including when that word was full.
  - flush_done is asserted only on the cnt==0 path.
- Simultaneous events:
  - flush in the same cycle as a fifo_r_en: the in-flight read is still captured (pend), then the partial word is emitted.
  - fifo_empty rising while pend=1: the capture is still taken, because the data was already read.
- Reset mid-word discards captured lanes and the pending read. No word is emitted.
- The block never reads while fifo_empty=1, so it never under-reads the fifo.

Test Plan:
- Reset then steady stream:
  - Stimulus: release rst, fifo preloaded with 8'h11,22,33,44,55,66,77,88; m_ready=1.
  - Required: m_data=32'h44332211 (m_count=4), then 32'h88776655; words_sent=2; fifo_r_en never high with fifo_empty=1.
- Backpressure:
  - Stimulus: same data, m_ready=0 for 10 cycles after m_valid.
  - Required: m_data holds 32'h44332211; fifo_r_en=0 throughout HOLD; the second word follows once m_ready=1.
- Partial flush:
  - Stimulus: write 8'hA1,8'hB2 only, wait until both are captured, pulse flush.
  - Required: m_data=32'h0000B2A1, m_count=2; after accept, flush_done pulses once; words_sent=1.
- Flush with nothing captured:
  - Stimulus: empty fifo, cnt=0, pulse flush.
  - Required: flush_done=1 for exactly one cycle two cycles later; m_valid stays 0.
- Flush during an in-flight read:
  - Stimulus: assert flush in the same cycle fifo_r_en reads 8'h5C with cnt=1 (lane0=8'h10).
  - Required: m_data=32'h00005C10, m_count=2.
- Async reset mid-word and counter wrap:
  - Stimulus: drop rst between clock edges with cnt=3.
  - Required: all outputs are 0 immediately; the next word starts at lane 0.
  - Stimulus: with CW=4, accept 16 words.
  - Required: words_sent wraps to 0.

Source files
------------

// File: rtl/fifo_drain_packer.sv
// fifo_drain_packer: drains DW-bit entries from a synchronous fifo and packs
// PACK consecutive entries into one DW*PACK word on a valid/ready stream.
// A flush request emits the captured partial word, or pulses flush_done
// when nothing is captured.

// One packing lane: holds a single fifo entry until the word is accepted.
module fifo_drain_packer_lane #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr,
    input  logic          clr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] q_nxt
);
    logic [DW-1:0] q;

    // Next lane value; clear wins over capture, exposed so the top can pack
    // a word in the same cycle as its final capture.
    always_comb begin
        q_nxt = q;
        if (clr)
            q_nxt = '0;
        else if (wr)
            q_nxt = din;
    end

    // Lane storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            q <= '0;
        else
            q <= q_nxt;
    end
endmodule

module fifo_drain_packer #(
    parameter int DW   = 8,
    parameter int PACK = 4,
    parameter int CW   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fifo_empty,
    input  logic [DW-1:0]              fifo_rd_data,
    output logic                       fifo_r_en,
    input  logic                       flush,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DW*PACK-1:0]         m_data,
    output logic [$clog2(PACK+1)-1:0]  m_count,
    output logic                       flush_done,
    output logic [CW-1:0]              words_sent
);
    localparam int CNTW = $clog2(PACK+1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t                  state, state_nxt;
    logic [CNTW-1:0]         cnt;
    logic                    pend;
    logic                    flush_req;
    logic [PACK-1:0][DW-1:0] lane_nxt;
    logic [PACK-1:0]         lane_wr;
    logic                    lane_clr;
    logic [CNTW:0]           cnt_inc;
    logic [CNTW:0]           in_use;
    logic                    full_cap;
    logic                    part_emit;
    logic                    flush_empty;
    logic                    accept;

    // Lanes already captured plus the read still in flight bound new reads.
    assign cnt_inc     = {1'b0, cnt} + 1'b1;
    assign in_use      = {1'b0, cnt} + {{CNTW{1'b0}}, pend};
    assign full_cap    = (state == FILL) && pend && (cnt_inc == (CNTW+1)'(PACK));
    // A flush waits for any in-flight read to land before acting.
    assign part_emit   = (state == FILL) && !pend && flush_req && (cnt != '0);
    assign flush_empty = (state == FILL) && !pend && flush_req && (cnt == '0);
    assign accept      = (state == HOLD) && m_valid && m_ready;
    assign lane_clr    = accept;

    for (genvar i = 0; i < PACK; i++) begin : g_lane
        assign lane_wr[i] = (state == FILL) && pend && (cnt == CNTW'(i));
        fifo_drain_packer_lane #(.DW(DW)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .wr    (lane_wr[i]),
            .clr   (lane_clr),
            .din   (fifo_rd_data),
            .q_nxt (lane_nxt[i])
        );
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= FILL;
        else
            state <= state_nxt;
    end

    // Next state: a full capture or a partial flush parks the word in HOLD.
    always_comb begin
        state_nxt = state;
        case (state)
            FILL: if (full_cap || part_emit) state_nxt = HOLD;
            HOLD: if (accept)                state_nxt = FILL;
            default:                         state_nxt = FILL;
        endcase
    end

    // Fifo read strobe; held low in reset and whenever a flush is pending.
    always_comb begin
        fifo_r_en = 1'b0;
        if (rst && (state == FILL) && !fifo_empty && !flush_req &&
            (in_use < (CNTW+1)'(PACK)))
            fifo_r_en = 1'b1;
    end

    // Capture count, flush bookkeeping and the output word register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            pend       <= 1'b0;
            flush_req  <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_count    <= '0;
            flush_done <= 1'b0;
            words_sent <= '0;
        end else begin
            pend       <= fifo_r_en;
            flush_done <= flush_empty;
            // Extra flush requests while one is pending are absorbed.
            flush_req  <= flush_req ? !flush_empty : flush;
            if (accept) begin
                m_valid    <= 1'b0;
                cnt        <= '0;
                words_sent <= words_sent + 1'b1;
            end else if ((state == FILL) && pend) begin
                cnt <= cnt_inc[CNTW-1:0];
                if (full_cap) begin
                    m_valid <= 1'b1;
                    m_data  <= lane_nxt;
                    m_count <= CNTW'(PACK);
                end
            end else if (part_emit) begin
                m_valid <= 1'b1;
                m_data  <= lane_nxt;
                m_count <= cnt;
            end
        end
    end
endmodule
